vga_block_timing: RTL

//  Generates 640x480@60 VGA raster timing and converts it to 16x16-pixel block coordinates.

---
 rtl/vga_block_timing.sv | 88 ++++++++
 1 files changed

// File: rtl/vga_block_timing.sv
// 640x480@60 VGA raster timing with 16x16 block coordinates.
// Registered outputs trail the pixel counters by one clk.
module vga_block_timing #(
   parameter int PIX_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync,
   output logic       vsync,
   output logic [5:0] XPos,
   output logic [4:0] YPos,
   output logic       valid,
   output logic       frame_start
);

   localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] H_S0   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] H_S1   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_LAST =
      10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);

   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] V_S0   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] V_S1   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_LAST =
      10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

   logic [DW-1:0] div_cnt;
   logic [9:0]    h_cnt;
   logic [9:0]    v_cnt;
   logic          pix_en;
   logic          h_wrap;
   logic          v_wrap;

   assign pix_en = (div_cnt == DIV_LAST);
   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
         if (pix_en) begin
            if (h_wrap) begin
               h_cnt <= '0;
               v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   // Block coordinates are plain truncations; consumers gate with valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         valid       <= 1'b0;
         XPos        <= '0;
         YPos        <= '0;
         frame_start <= 1'b0;
      end else begin
         valid       <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
         hsync       <= !((h_cnt >= H_S0) && (h_cnt <= H_S1));
         vsync       <= !((v_cnt >= V_S0) && (v_cnt <= V_S1));
         XPos        <= h_cnt[9:4];
         YPos        <= v_cnt[8:4];
         frame_start <= pix_en && h_wrap && v_wrap;
      end
   end

endmodule
